// File: rtl/if_fetch.sv
// miniRV instruction-fetch stage: PC, imem req/ack sequencer and a small instruction FIFO feeding decode.
// Optional IF_PERF_CNT_EN adds fetched/dropped ack counters.
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INS    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_ins,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_REQ, S_DROP, S_HOLD} state_t;

  state_t           state, state_nxt;
  logic [31:0]      pc, pc_nxt;
  logic [31:0]      drop_addr, drop_addr_nxt;
  logic [31:0]      ins_mem [FIFO_DEPTH];
  logic [31:0]      pc_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count, count_nxt;
  logic             push, pop, discard;
  logic [31:0]      target;
  logic             unused_pc_bits;

  assign target         = {redirect_pc[31:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    drop_addr_nxt = drop_addr;
    push          = 1'b0;
    discard       = 1'b0;
    // A redirect flushes the FIFO, so it also suppresses the pop.
    pop           = (count != '0) && id_ready && !redirect;
    case (state)
      S_REQ: begin
        if (redirect) begin
          pc_nxt = target;
          if (imem_ack) begin
            discard = 1'b1;
          end else begin
            state_nxt     = S_DROP;
            drop_addr_nxt = pc;
          end
        end else if (imem_ack) begin
          push   = 1'b1;
          pc_nxt = pc + 32'd4;
          if ((count + CNT_W'(1)) == DEPTH_C && !pop) state_nxt = S_HOLD;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          discard   = 1'b1;
          state_nxt = S_REQ;
        end
        if (redirect) pc_nxt = target;
      end
      S_HOLD: begin
        if (redirect) begin
          pc_nxt    = target;
          state_nxt = S_REQ;
        end else if (pop) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
    count_nxt = redirect ? '0 : count + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
      count     <= '0;
      head      <= '0;
      tail      <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      drop_addr <= drop_addr_nxt;
      count     <= count_nxt;
      if (redirect) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= (tail == LAST_PTR) ? '0 : tail + PTR_W'(1);
        if (pop)  head <= (head == LAST_PTR) ? '0 : head + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ins_mem[tail] <= imem_rdata;
      pc_mem[tail]  <= pc;
    end
  end

  assign imem_req  = !rst && (state != S_HOLD);
  assign imem_addr = (state == S_DROP) ? drop_addr : pc;
  assign id_valid  = (count != '0);
  assign id_ins    = id_valid ? ins_mem[head] : NOP_INS;
  assign id_pc     = id_valid ? pc_mem[head] : pc;
  assign id_pc4    = id_pc + 32'd4;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (push)    perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (discard) perf_drop_cnt  <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch: a queue-based fetch model predicts req/addr and the decode-side outputs each cycle.
module tb_if_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_ins, id_pc, id_pc4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_drop_cnt;
`endif

  always #5 clk = ~clk;

  if_fetch #(
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH),
    .NOP_INS   (NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_ins     (id_ins),
    .id_pc      (id_pc),
    .id_pc4     (id_pc4)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_drop_cnt (perf_drop_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic bit pct(input int unsigned p);
    return $urandom_range(99) < p;
  endfunction

  // Model: queue of buffered PCs, next fetch PC, and an outstanding read that must be thrown away.
  logic [31:0] q[$];
  logic [31:0] m_pc = RESET_PC;
  bit          stale = 1'b0;
  logic [31:0] stale_addr = '0;
  bit          just_reset = 1'b0;
  logic [31:0] m_fetch = '0;
  logic [31:0] m_drop = '0;

  task automatic model_step();
    bit req_now, ack_eff;
    if (rst) begin
      q.delete();
      m_pc = RESET_PC;
      stale = 1'b0;
      just_reset = 1'b1;
      m_fetch = '0;
      m_drop = '0;
      return;
    end
    just_reset = 1'b0;
    req_now = (q.size() < int'(DEPTH));
    ack_eff = imem_ack && req_now;
    if (redirect) begin
      if (ack_eff) begin
        m_drop++;
        stale = 1'b0;
      end else if (req_now && !stale) begin
        stale = 1'b1;
        stale_addr = m_pc;
      end
      q.delete();
      m_pc = redirect_pc & ~32'd3;
    end else if (stale) begin
      if (ack_eff) begin
        stale = 1'b0;
        m_drop++;
      end
    end else begin
      if (q.size() > 0 && id_ready) void'(q.pop_front());
      if (ack_eff) begin
        q.push_back(m_pc);
        m_pc += 32'd4;
        m_fetch++;
      end
    end
  endtask

  typedef struct {
    int unsigned ack, rdy, redir, rstp, cycles;
  } phase_t;

  phase_t phases [8] = '{
    '{100, 100,  0, 0, 200},
    '{100,   0,  0, 0,  20},
    '{100, 100,  0, 0,  20},
    '{ 30,  60, 10, 1, 600},
    '{100,  50, 25, 0, 400},
    '{ 20, 100,  5, 2, 600},
    '{ 70,  30, 15, 2, 600},
    '{ 50,  80,  8, 1, 600}
  };

  initial begin
    logic [31:0] exp_addr;
    bit          exp_req;
    repeat (3) begin
      @(posedge clk);
      model_step();
    end
    foreach (phases[p]) begin
      for (int unsigned c = 0; c < phases[p].cycles; c++) begin
        @(negedge clk);
        exp_req = !rst && (q.size() < int'(DEPTH));
        check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) begin
          exp_addr = stale ? stale_addr : m_pc;
          check("imem_addr", imem_addr, exp_addr);
        end
        check("id_valid", {31'b0, id_valid}, {31'b0, q.size() != 0});
        check("id_ins", id_ins, (q.size() != 0) ? mem_word(q[0]) : NOP);
        if (q.size() != 0) begin
          check("id_pc", id_pc, q[0]);
          check("id_pc4", id_pc4, q[0] + 32'd4);
        end else if (just_reset) begin
          check("id_pc_rst", id_pc, RESET_PC);
          check("id_pc4_rst", id_pc4, RESET_PC + 32'd4);
        end
`ifdef IF_PERF_CNT_EN
        check("perf_fetch", perf_fetch_cnt, m_fetch);
        check("perf_drop", perf_drop_cnt, m_drop);
`endif
        rst      = pct(phases[p].rstp);
        redirect = pct(phases[p].redir);
        case ($urandom_range(3))
          0:       redirect_pc = 32'h0000_0103;
          1:       redirect_pc = 32'hFFFF_FFF4;
          default: redirect_pc = $urandom;
        endcase
        id_ready = pct(phases[p].rdy);
        #1;
        imem_ack   = imem_req && pct(phases[p].ack);
        imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
        @(posedge clk);
        model_step();
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
